mano_timing_int_ctrl: RTL and testbench

- Timing and interrupt sequencer for the 8-bit Mano-style CPU.
- Holds the 3-bit sequence counter (SC) and drives the one-hot timing bus T[7:0] consumed by the control unit.
- Holds the run/halt state, the interrupt-enable flip-flop IEN and the interrupt-cycle flip-flop R.
- Sequences the fetch → decode → execute cycle and the RT0–RT2 interrupt cycle.

---
 rtl/mano_timing_int_ctrl.sv | 157 +++++++++++++++
 tb/tb_mano_timing_int_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mano_timing_int_ctrl.sv
// Timing and interrupt sequencer for the 8-bit Mano-style CPU: SC/T timing, run/halt, IEN and R.
// Optional single-step pause is enabled with `define SEQ_SINGLE_STEP_EN (adds STEP_MODE, STEP).
module mano_timing_int_ctrl #(
    parameter int NT     = 8,
    parameter int SC_MAX = NT - 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic                    HLT,
    input  logic                    CLRSEQ,
    input  logic                    ION,
    input  logic                    IOF,
    input  logic                    FGI,
    input  logic                    FGO,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                    STEP_MODE,
    input  logic                    STEP,
`endif
    output logic [NT-1:0]           T,
    output logic [$clog2(NT)-1:0]   SC,
    output logic                    RUN,
    output logic                    IEN,
    output logic                    R,
    output logic                    INT_ACK,
    output logic                    SEQ_ERR
);

    localparam int SCW = $clog2(NT);
    localparam logic [NT-1:0] T_ONE = {{(NT-1){1'b0}}, 1'b1};

    // The interrupt cycle is the RUN state with r_r set.
    localparam logic [1:0] ST_HALT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    logic [1:0]     r_state;
    logic [SCW-1:0] r_sc;
    logic [NT-1:0]  r_t;
    logic           r_ien;
    logic           r_r;
    logic           r_seq_err;

    logic [1:0]     w_state;
    logic [SCW-1:0] w_sc;
    logic [NT-1:0]  w_t;
    logic           w_ien;
    logic           w_r;
    logic           w_seq_err;
    logic           w_rt2;
    logic           w_early;
    logic           w_end;
    logic           w_step_mode;
    logic           w_step;

`ifdef SEQ_SINGLE_STEP_EN
    assign w_step_mode = STEP_MODE;
    assign w_step      = STEP;
`else
    assign w_step_mode = 1'b0;
    assign w_step      = 1'b0;
`endif

    assign w_rt2   = r_r & r_t[2];
    assign w_early = |r_t[2:0];

    always_comb begin
        w_state   = r_state;
        w_sc      = r_sc;
        w_ien     = r_ien;
        w_r       = r_r;
        w_seq_err = r_seq_err;
        w_end     = 1'b0;
        case (r_state)
            ST_HALT: begin
                if (START) begin
                    w_state = ST_RUN;
                    w_sc    = '0;
                end
            end
            ST_RUN: begin
                if (HLT) begin
                    w_state = ST_HALT;
                    w_sc    = '0;
                    w_r     = 1'b0;
                end else begin
                    if (w_rt2)
                        w_ien = 1'b0;
                    else if (IOF)
                        w_ien = 1'b0;
                    else if (ION)
                        w_ien = 1'b1;
                    // CLRSEQ is dropped only during RT0..RT2; a pending R still needs the
                    // running instruction's CLRSEQ to reach RT0.
                    if (w_rt2) begin
                        w_r   = 1'b0;
                        w_sc  = '0;
                        w_end = 1'b1;
                    end else if (CLRSEQ && !(r_r && w_early)) begin
                        w_sc  = '0;
                        w_end = 1'b1;
                    end else if (r_sc == SCW'(SC_MAX)) begin
                        w_sc      = '0;
                        w_seq_err = 1'b1;
                    end else begin
                        w_sc = r_sc + SCW'(1);
                    end
                    if (!CLRSEQ && !r_r && !w_early && r_ien && (FGI | FGO))
                        w_r = 1'b1;
                    if (w_end && w_step_mode)
                        w_state = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (HLT) begin
                    w_state = ST_HALT;
                    w_r     = 1'b0;
                end else if (w_step) begin
                    w_state = ST_RUN;
                end
            end
            default: begin
                w_state = ST_HALT;
                w_sc    = '0;
                w_r     = 1'b0;
            end
        endcase
        w_t = (w_state == ST_RUN) ? (T_ONE << w_sc) : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_HALT;
            r_sc      <= '0;
            r_t       <= '0;
            r_ien     <= 1'b0;
            r_r       <= 1'b0;
            r_seq_err <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_sc      <= w_sc;
            r_t       <= w_t;
            r_ien     <= w_ien;
            r_r       <= w_r;
            r_seq_err <= w_seq_err;
        end
    end

    assign T       = r_t;
    assign SC      = r_sc;
    assign RUN     = (r_state != ST_HALT);
    assign IEN     = r_ien;
    assign R       = r_r;
    assign INT_ACK = w_rt2;
    assign SEQ_ERR = r_seq_err;

endmodule

// File: tb/tb_mano_timing_int_ctrl.sv
// Directed self-checking bench for mano_timing_int_ctrl: timing sequence, wrap error, interrupt cycle, halt, reset.
module tb_mano_timing_int_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       START = 1'b0;
    logic       HLT = 1'b0;
    logic       CLRSEQ = 1'b0;
    logic       ION = 1'b0;
    logic       IOF = 1'b0;
    logic       FGI = 1'b0;
    logic       FGO = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    logic       STEP_MODE = 1'b0;
    logic       STEP = 1'b0;
`endif
    logic [7:0] T;
    logic [2:0] SC;
    logic       RUN, IEN, R, INT_ACK, SEQ_ERR;

    int checks = 0;
    int passes = 0;

    mano_timing_int_ctrl #(.NT(8), .SC_MAX(7)) dut (
        .CLK(CLK), .RST(RST), .START(START), .HLT(HLT), .CLRSEQ(CLRSEQ),
        .ION(ION), .IOF(IOF), .FGI(FGI), .FGO(FGO),
`ifdef SEQ_SINGLE_STEP_EN
        .STEP_MODE(STEP_MODE), .STEP(STEP),
`endif
        .T(T), .SC(SC), .RUN(RUN), .IEN(IEN), .R(R), .INT_ACK(INT_ACK), .SEQ_ERR(SEQ_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start();
        RST = 1'b1; tick(); RST = 1'b0;
        START = 1'b1; tick(); START = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; tick(); tick(); RST = 1'b0;
        checks++; if (T !== 8'h00) $display("FAIL reset_T got=%h exp=%h", T, 8'h00); else passes++;
        checks++; if (SC !== 3'd0) $display("FAIL reset_SC got=%0d exp=%0d", SC, 0); else passes++;
        checks++; if ({RUN, IEN, R, INT_ACK, SEQ_ERR} !== 5'b0)
            $display("FAIL reset_flags got=%b exp=%b", {RUN, IEN, R, INT_ACK, SEQ_ERR}, 5'b0); else passes++;
    endtask

    task automatic test_sequence();
        logic [7:0] exp_t [4] = '{8'h02, 8'h04, 8'h08, 8'h10};
        do_start();
        checks++; if ({RUN, T, SC} !== {1'b1, 8'h01, 3'd0})
            $display("FAIL start_T0 got=%b/%h/%0d exp=1/01/0", RUN, T, SC); else passes++;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (T !== exp_t[i] || SC !== 3'(i + 1))
                $display("FAIL seq_T%0d got=%h/%0d exp=%h/%0d", i + 1, T, SC, exp_t[i], i + 1); else passes++;
        end
        CLRSEQ = 1'b1; tick(); CLRSEQ = 1'b0;
        checks++; if ({T, SC} !== {8'h01, 3'd0})
            $display("FAIL clrseq_T0 got=%h/%0d exp=01/0", T, SC); else passes++;
    endtask

    task automatic test_wrap();
        do_start();
        for (int i = 0; i < 7; i++) tick();
        checks++; if ({T, SC, SEQ_ERR} !== {8'h80, 3'd7, 1'b0})
            $display("FAIL wrap_T7 got=%h/%0d/%b exp=80/7/0", T, SC, SEQ_ERR); else passes++;
        tick();
        checks++; if ({T, SC, SEQ_ERR} !== {8'h01, 3'd0, 1'b1})
            $display("FAIL wrap_to_T0 got=%h/%0d/%b exp=01/0/1", T, SC, SEQ_ERR); else passes++;
        CLRSEQ = 1'b1; tick(); CLRSEQ = 1'b0; tick(); tick();
        checks++; if (SEQ_ERR !== 1'b1) $display("FAIL seq_err_sticky got=%b exp=1", SEQ_ERR); else passes++;
        RST = 1'b1; tick(); RST = 1'b0;
        checks++; if (SEQ_ERR !== 1'b0) $display("FAIL seq_err_rst got=%b exp=0", SEQ_ERR); else passes++;
    endtask

    task automatic test_interrupt();
        do_start();
        tick();
        ION = 1'b1; FGI = 1'b1; tick(); ION = 1'b0;
        checks++; if ({IEN, R, SC} !== {1'b1, 1'b0, 3'd2})
            $display("FAIL ion_IEN got=%b/%b/%0d exp=1/0/2", IEN, R, SC); else passes++;
        tick();
        checks++; if (R !== 1'b0) $display("FAIL r_not_at_T2 got=%b exp=0", R); else passes++;
        tick();
        checks++; if ({R, SC} !== {1'b1, 3'd4}) $display("FAIL r_set got=%b/%0d exp=1/4", R, SC); else passes++;
        CLRSEQ = 1'b1; tick(); CLRSEQ = 1'b0;
        checks++; if ({R, T, SC, INT_ACK} !== {1'b1, 8'h01, 3'd0, 1'b0})
            $display("FAIL rt0 got=%b/%h/%0d/%b exp=1/01/0/0", R, T, SC, INT_ACK); else passes++;
        CLRSEQ = 1'b1; tick(); CLRSEQ = 1'b0;
        checks++; if ({SC, INT_ACK} !== {3'd1, 1'b0})
            $display("FAIL rt1_clrseq_ignored got=%0d/%b exp=1/0", SC, INT_ACK); else passes++;
        tick();
        checks++; if ({T, INT_ACK, R} !== {8'h04, 1'b1, 1'b1})
            $display("FAIL rt2_ack got=%h/%b/%b exp=04/1/1", T, INT_ACK, R); else passes++;
        tick();
        checks++; if ({R, IEN, INT_ACK, T, SC} !== {1'b0, 1'b0, 1'b0, 8'h01, 3'd0})
            $display("FAIL after_rt2 got=%b/%b/%b/%h/%0d exp=0/0/0/01/0", R, IEN, INT_ACK, T, SC); else passes++;
        FGI = 1'b0;
    endtask

    task automatic test_ien_conflict();
        do_start();
        ION = 1'b1; IOF = 1'b1; FGO = 1'b1; tick(); ION = 1'b0; IOF = 1'b0;
        checks++; if (IEN !== 1'b0) $display("FAIL ion_iof_conflict got=%b exp=0", IEN); else passes++;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (R !== 1'b0) $display("FAIL r_no_ien_%0d got=%b exp=0", i, R); else passes++;
        end
        FGO = 1'b0;
    endtask

    task automatic test_halt();
        do_start();
        tick();
        ION = 1'b1; tick(); ION = 1'b0;
        START = 1'b1; tick(); START = 1'b0;
        checks++; if (SC !== 3'd3) $display("FAIL start_ignored_run got=%0d exp=3", SC); else passes++;
        tick(); tick();
        checks++; if (T !== 8'h20) $display("FAIL halt_at_T5 got=%h exp=20", T); else passes++;
        HLT = 1'b1; tick(); HLT = 1'b0;
        checks++; if ({RUN, T, SC, IEN} !== {1'b0, 8'h00, 3'd0, 1'b1})
            $display("FAIL halted got=%b/%h/%0d/%b exp=0/00/0/1", RUN, T, SC, IEN); else passes++;
        tick();
        checks++; if ({RUN, T} !== {1'b0, 8'h00}) $display("FAIL halt_hold got=%b/%h exp=0/00", RUN, T); else passes++;
        START = 1'b1; tick(); START = 1'b0;
        checks++; if ({RUN, T, SC} !== {1'b1, 8'h01, 3'd0})
            $display("FAIL restart got=%b/%h/%0d exp=1/01/0", RUN, T, SC); else passes++;
    endtask

    task automatic test_back_to_back();
        do_start();
        ION = 1'b1; tick(); ION = 1'b0;
        tick(); tick();
        FGI = 1'b1; CLRSEQ = 1'b1; tick(); CLRSEQ = 1'b0;
        checks++; if ({R, SC} !== {1'b0, 3'd0}) $display("FAIL clrseq_blocks_r got=%b/%0d exp=0/0", R, SC); else passes++;
        tick(); tick(); tick();
        checks++; if ({R, SC} !== {1'b0, 3'd3}) $display("FAIL r_wait_T3 got=%b/%0d exp=0/3", R, SC); else passes++;
        tick();
        checks++; if (R !== 1'b1) $display("FAIL r_reeval got=%b exp=1", R); else passes++;
        HLT = 1'b1; tick(); HLT = 1'b0;
        checks++; if ({RUN, R, T} !== {1'b0, 1'b0, 8'h00})
            $display("FAIL hlt_clears_r got=%b/%b/%h exp=0/0/00", RUN, R, T); else passes++;
        FGI = 1'b0;
    endtask

    task automatic test_rst_mid_int();
        do_start();
        ION = 1'b1; FGI = 1'b1; tick(); ION = 1'b0;
        tick(); tick(); tick();
        CLRSEQ = 1'b1; tick(); CLRSEQ = 1'b0;
        tick();
        checks++; if ({R, SC, IEN} !== {1'b1, 3'd1, 1'b1})
            $display("FAIL at_rt1 got=%b/%0d/%b exp=1/1/1", R, SC, IEN); else passes++;
        RST = 1'b1; tick(); RST = 1'b0;
        checks++; if ({T, SC} !== {8'h00, 3'd0}) $display("FAIL rst_rt1_TSC got=%h/%0d exp=00/0", T, SC); else passes++;
        checks++; if ({RUN, IEN, R, INT_ACK, SEQ_ERR} !== 5'b0)
            $display("FAIL rst_rt1_flags got=%b exp=%b", {RUN, IEN, R, INT_ACK, SEQ_ERR}, 5'b0); else passes++;
        FGI = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_wrap();
        test_interrupt();
        test_ien_conflict();
        test_halt();
        test_back_to_back();
        test_rst_mid_int();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
